fifo_level: RTL and testbench

FIFO_LEVEL -- requirements
Module: fifo_level

---
 rtl/fifo_level.sv | 96 +++++++++
 tb/tb_fifo_level.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_level.sv
// rtl/fifo_level.sv - synchronous FIFO with registered occupancy, threshold flags and sticky error flags
module fifo_level #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic                    w_en,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic                    r_en,
    input  logic                    clr_err,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic                    r_empty,
    output logic                    w_full,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    assign r_empty      = (level == '0);
    assign w_full       = (level == LW'(DEPTH));
    assign almost_full  = (level >= LW'(AFULL_THRESH));
    assign almost_empty = (level <= LW'(AEMPTY_THRESH));

    assign wr_acc = clk_en & w_en & ~w_full;
    assign rd_acc = clk_en & r_en & ~r_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr_acc && !rd_acc)
                level <= level + LW'(1);
            else if (rd_acc && !wr_acc)
                level <= level - LW'(1);
        end
    end

    // A rejected request sets its flag even if clr_err is asserted in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clk_en) begin
            if (w_en && w_full)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
            if (r_en && r_empty)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end

    // Storage is intentionally left without reset.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= w_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign r_data = mem[rd_ptr];
        end else begin : g_reg
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    r_data <= '0;
                else if (rd_acc)
                    r_data <= mem[rd_ptr];
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_level.sv
// tb/tb_fifo_level.sv - randomized scoreboard bench for fifo_level in registered and FWFT read modes
module tb_fifo_level;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clk_en = 1'b1;
    logic          w_en = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic          r_en = 1'b0;
    logic          clr_err = 1'b0;

    logic [DW-1:0] r_data, f_r_data;
    logic          r_empty, w_full, almost_full, almost_empty, overflow, underflow;
    logic          f_r_empty, f_w_full, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0]    level, f_level;

    fifo_level #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .w_en(w_en), .w_data(w_data),
        .r_en(r_en), .clr_err(clr_err), .r_data(r_data), .r_empty(r_empty),
        .w_full(w_full), .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow)
    );

    fifo_level #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .clk_en(clk_en), .w_en(w_en), .w_data(w_data),
        .r_en(r_en), .clr_err(clr_err), .r_data(f_r_data), .r_empty(f_r_empty),
        .w_full(f_w_full), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
        .level(f_level), .overflow(f_overflow), .underflow(f_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int mq[$];
    int exp_q[$];
    bit m_ov = 1'b0;
    bit m_uf = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        chk("level", int'(level), mq.size());
        chk("r_empty", int'(r_empty), int'(mq.size() == 0));
        chk("w_full", int'(w_full), int'(mq.size() == DEPTH));
        chk("almost_full", int'(almost_full), int'(mq.size() >= DEPTH - 2));
        chk("almost_empty", int'(almost_empty), int'(mq.size() <= 2));
        chk("overflow", int'(overflow), int'(m_ov));
        chk("underflow", int'(underflow), int'(m_uf));
        chk("fwft_level", int'(f_level), mq.size());
        chk("fwft_r_empty", int'(f_r_empty), int'(mq.size() == 0));
        if (mq.size() > 0)
            chk("fwft_r_data", int'(f_r_data), mq[0]);
    endtask

    // Drive one cycle from a negedge, advance the reference model, check after the edge.
    task automatic step(input bit w, input int wd, input bit r, input bit ce, input bit clr);
        w_en    = w;
        w_data  = DW'(wd);
        r_en    = r;
        clk_en  = ce;
        clr_err = clr;
        if (ce) begin
            bit full;
            bit empty;
            full  = (mq.size() == DEPTH);
            empty = (mq.size() == 0);
            if (r && !empty)
                exp_q.push_back(mq.pop_front());
            if (w && !full)
                mq.push_back(wd & 8'hFF);
            if (w && full)
                m_ov = 1'b1;
            else if (clr)
                m_ov = 1'b0;
            if (r && empty)
                m_uf = 1'b1;
            else if (clr)
                m_uf = 1'b0;
        end
        @(negedge clk);
        check_status();
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic apply_reset();
        #2;
        reset = 1'b0;
        mq.delete();
        m_ov = 1'b0;
        m_uf = 1'b0;
        #1;
        check_status();
        chk("reset_r_data", int'(r_data), 0);
        w_en   = 1'b1;
        r_en   = 1'b1;
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        check_status();
        chk("reset_hold_r_data", int'(r_data), 0);
        w_en  = 1'b0;
        r_en  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_status();
    endtask

    // Monitor: a read handshake seen at the edge must deliver the scoreboard's next word.
    always @(posedge clk) begin
        if (reset && clk_en && r_en && !r_empty) begin
            #1;
            if (exp_q.size() == 0)
                chk("r_data_unexpected_read", 1, 0);
            else
                chk("r_data", int'(r_data), exp_q.pop_front());
        end
    end

    initial begin
        w_en = 1'b1;
        w_data = 8'h5A;
        repeat (2) @(negedge clk);
        check_status();
        chk("reset_r_data", int'(r_data), 0);
        w_en  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_status();

        step(1, 15, 0, 1, 0);
        step(1, 69, 0, 1, 0);
        step(1, 42, 0, 1, 0);
        repeat (3) step(0, 0, 1, 1, 0);
        idle();

        for (int i = 0; i < DEPTH; i++)
            step(1, 100 + i, 0, 1, 0);
        step(1, 200, 0, 1, 0);
        step(0, 0, 0, 1, 1);

        step(1, 201, 0, 1, 0);
        step(1, 202, 1, 1, 0);
        step(0, 0, 0, 1, 1);

        while (mq.size() > 0)
            step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        step(1, 33, 1, 1, 0);
        idle();
        step(0, 0, 1, 1, 1);
        idle();

        step(1, 0, 0, 1, 0);
        for (int i = 1; i < 40; i++) begin
            if (i == 20)
                repeat (3) step(1, $urandom_range(0, 255), 1, 0, 1);
            step(1, i * 3, 1, 1, 0);
        end
        step(0, 0, 1, 1, 0);
        idle();

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 55, $urandom_range(0, 255),
                 $urandom_range(0, 99) < 50, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 15) == 0);

        while (mq.size() > 0)
            step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        step(1, 7, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            step(1, 50 + i, 0, 1, 0);
        apply_reset();
        step(1, 171, 0, 1, 0);
        step(1, 172, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        idle();
        chk("scoreboard_final", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
